// File: rtl/dice_game_mp.sv
// dice_game_mp: multi-player "race to an exact target" dice game.
//
// A free-running roll counter (1..FACES) is sampled by a button press. The
// current player then either takes the roll or passes. A take that lands
// exactly on TARGET wins. A take that overshoots is rejected and pulses bust.
// After MAX_TURNS completed turns without a win the game ends in a draw.
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst     - synchronous active-high reset
//   btn     - button level; only its rising edge acts
//   choice  - in CHOOSE: 1 = take the roll, 0 = pass
//   state   - game state (IDLE=0, ROLL=1, CHOOSE=2, DONE=3)
//   num     - last latched roll
//   player  - current player index
//   score   - current player's score
//   scores  - all scores, player i at [i*SCORE_W +: SCORE_W]
//   turns   - completed turn count
//   won     - high in DONE when a player won
//   winner  - winning player index (valid when won=1)
//   bust    - one-cycle pulse on a rejected take
module dice_game_mp #(
  parameter int PLAYERS   = 2,
  parameter int FACES     = 6,
  parameter int TARGET    = 15,
  parameter int MAX_TURNS = 12,
  parameter int SCORE_W   = 4,
  parameter int TURN_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn,
  input  logic                       choice,
  output logic [1:0]                 state,
  output logic [2:0]                 num,
  output logic [1:0]                 player,
  output logic [SCORE_W-1:0]         score,
  output logic [PLAYERS*SCORE_W-1:0] scores,
  output logic [TURN_W-1:0]          turns,
  output logic                       won,
  output logic [1:0]                 winner,
  output logic                       bust
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROLL   = 2'd1,
    CHOOSE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_r, state_n;
  logic               btn_q;
  logic [2:0]         cnt_r, cnt_n;
  logic [2:0]         num_r, num_n;
  logic [1:0]         player_r, player_n;
  // Four slots regardless of PLAYERS so the 2-bit player index always
  // addresses the array exactly; slots >= PLAYERS are never selected.
  logic [SCORE_W-1:0] sc_r [4];
  logic [SCORE_W-1:0] sc_n [4];
  logic [SCORE_W-1:0] score_r, score_n;
  logic [TURN_W-1:0]  turns_r, turns_n, turns_inc;
  logic               won_r, won_n;
  logic [1:0]         winner_r, winner_n;
  logic               bust_r, bust_n;
  logic               press;
  logic [SCORE_W:0]   sum;

  assign press = btn & ~btn_q;

  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    num_n     = num_r;
    player_n  = player_r;
    sc_n      = sc_r;
    turns_n   = turns_r;
    won_n     = won_r;
    winner_n  = winner_r;
    bust_n    = 1'b0;
    sum       = '0;
    turns_inc = turns_r + 1'b1;

    case (state_r)
      IDLE: begin
        if (press) begin
          state_n = ROLL;
          cnt_n   = 3'd1;
        end
      end
      ROLL: begin
        cnt_n = (cnt_r == 3'(FACES)) ? 3'd1 : cnt_r + 3'd1;
        if (press) begin
          num_n   = cnt_r;
          state_n = CHOOSE;
        end
      end
      CHOOSE: begin
        if (press) begin
          sum     = {1'b0, sc_r[player_r]} + (SCORE_W+1)'(num_r);
          turns_n = turns_inc;
          if (choice && (sum == (SCORE_W+1)'(TARGET))) begin
            sc_n[player_r] = sum[SCORE_W-1:0];
            won_n          = 1'b1;
            winner_n       = player_r;
            state_n        = DONE;
          end else begin
            if (choice && (sum > (SCORE_W+1)'(TARGET)))
              bust_n = 1'b1;
            else if (choice)
              sc_n[player_r] = sum[SCORE_W-1:0];
            player_n = (player_r == 2'(PLAYERS-1)) ? 2'd0 : player_r + 2'd1;
            if (turns_inc == TURN_W'(MAX_TURNS)) begin
              state_n = DONE;
            end else begin
              state_n = ROLL;
              cnt_n   = 3'd1;
            end
          end
        end
      end
      DONE: begin
        if (press) begin
          for (int unsigned i = 0; i < 4; i++) sc_n[i] = '0;
          turns_n  = '0;
          player_n = '0;
          won_n    = 1'b0;
          winner_n = '0;
          num_n    = '0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Registered copy of the selected score so the output is a flop.
    score_n = sc_n[player_n];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      btn_q    <= 1'b1;
      cnt_r    <= 3'd1;
      num_r    <= '0;
      player_r <= '0;
      for (int unsigned i = 0; i < 4; i++) sc_r[i] <= '0;
      score_r  <= '0;
      turns_r  <= '0;
      won_r    <= 1'b0;
      winner_r <= '0;
      bust_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      btn_q    <= btn;
      cnt_r    <= cnt_n;
      num_r    <= num_n;
      player_r <= player_n;
      sc_r     <= sc_n;
      score_r  <= score_n;
      turns_r  <= turns_n;
      won_r    <= won_n;
      winner_r <= winner_n;
      bust_r   <= bust_n;
    end
  end

  always_comb begin
    scores = '0;
    for (int unsigned i = 0; i < PLAYERS; i++)
      scores[i*SCORE_W +: SCORE_W] = sc_r[i];
  end

  assign state  = state_r;
  assign num    = num_r;
  assign player = player_r;
  assign score  = score_r;
  assign turns  = turns_r;
  assign won    = won_r;
  assign winner = winner_r;
  assign bust   = bust_r;

endmodule

// File: tb/tb_dice_game_mp.sv
// tb_dice_game_mp: cycle-level scoreboard bench for dice_game_mp.
// A behavioural game model predicts every output after each clock edge; the
// prediction is queued when inputs are driven and compared after the edge.
module tb_dice_game_mp;

  localparam int PLAYERS   = 2;
  localparam int FACES     = 6;
  localparam int TARGET    = 10;
  localparam int MAX_TURNS = 6;
  localparam int SCORE_W   = 4;
  localparam int TURN_W    = 4;

  logic                       clk;
  logic                       rst;
  logic                       btn;
  logic                       choice;
  logic [1:0]                 state;
  logic [2:0]                 num;
  logic [1:0]                 player;
  logic [SCORE_W-1:0]         score;
  logic [PLAYERS*SCORE_W-1:0] scores;
  logic [TURN_W-1:0]          turns;
  logic                       won;
  logic [1:0]                 winner;
  logic                       bust;

  dice_game_mp #(
    .PLAYERS(PLAYERS), .FACES(FACES), .TARGET(TARGET),
    .MAX_TURNS(MAX_TURNS), .SCORE_W(SCORE_W), .TURN_W(TURN_W)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .choice(choice),
    .state(state), .num(num), .player(player), .score(score),
    .scores(scores), .turns(turns), .won(won), .winner(winner), .bust(bust)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st; int nm; int pl; int sc; int scs; int tn; int wn; int wr; int bs;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Game model
  int m_state, m_num, m_player, m_turns, m_won, m_winner, m_bust, m_cnt, m_btnq;
  int m_sc[PLAYERS];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs (called at a negedge), predict, compare after the edge.
  task automatic cyc(input bit r, input bit b, input bit c);
    exp_t e;
    bit   pr;
    int   s;
    rst = r; btn = b; choice = c;
    pr = b && (m_btnq == 0);
    m_bust = 0;
    if (r) begin
      m_state = 0; m_num = 0; m_player = 0; m_turns = 0;
      m_won = 0; m_winner = 0; m_cnt = 1; m_btnq = 1;
      for (int i = 0; i < PLAYERS; i++) m_sc[i] = 0;
    end else begin
      m_btnq = b;
      case (m_state)
        0: if (pr) begin m_state = 1; m_cnt = 1; end
        1: begin
          if (pr) begin m_num = m_cnt; m_state = 2; end
          m_cnt = (m_cnt == FACES) ? 1 : m_cnt + 1;
        end
        2: if (pr) begin
          s = m_sc[m_player] + m_num;
          m_turns++;
          if (c && s == TARGET) begin
            m_sc[m_player] = s; m_won = 1; m_winner = m_player; m_state = 3;
          end else begin
            if (c && s > TARGET) m_bust = 1;
            else if (c) m_sc[m_player] = s;
            m_player = (m_player + 1) % PLAYERS;
            if (m_turns == MAX_TURNS) m_state = 3;
            else begin m_state = 1; m_cnt = 1; end
          end
        end
        default: if (pr) begin
          for (int i = 0; i < PLAYERS; i++) m_sc[i] = 0;
          m_turns = 0; m_player = 0; m_won = 0; m_winner = 0; m_num = 0; m_state = 0;
        end
      endcase
    end
    e.st = m_state; e.nm = m_num; e.pl = m_player; e.sc = m_sc[m_player];
    e.scs = 0;
    for (int i = 0; i < PLAYERS; i++) e.scs += m_sc[i] << (i * SCORE_W);
    e.tn = m_turns; e.wn = m_won; e.wr = m_winner; e.bs = m_bust;
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    check("state",  int'(state),  e.st);
    check("num",    int'(num),    e.nm);
    check("player", int'(player), e.pl);
    check("score",  int'(score),  e.sc);
    check("scores", int'(scores), e.scs);
    check("turns",  int'(turns),  e.tn);
    check("won",    int'(won),    e.wn);
    check("winner", int'(winner), e.wr);
    check("bust",   int'(bust),   e.bs);
  endtask

  task automatic start();
    cyc(0, 0, 0);
    cyc(0, 1, 0);
  endtask

  // In ROLL: wait until the counter will hold v at the next edge, then press.
  task automatic roll(input int v);
    cyc(0, 0, 1'($urandom));
    for (int k = 0; k < 2 * FACES && m_cnt != v; k++) cyc(0, 0, 1'($urandom));
    cyc(0, 1, 1'($urandom));
  endtask

  task automatic choose(input bit c);
    cyc(0, 0, c);
    cyc(0, 1, c);
  endtask

  task automatic take(input int v);
    roll(v);
    choose(1);
  endtask

  task automatic pass(input int v);
    roll(v);
    choose(0);
  endtask

  int trans;
  int prev_st;

  initial begin
    rst = 1'b1; btn = 1'b1; choice = 1'b0;
    m_btnq = 1;
    @(negedge clk);

    // Reset with btn held through it: no press on release
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1);
    check("held_through_reset_state", int'(state), 0);

    // Button held high for 10 cycles: exactly one IDLE->ROLL transition
    cyc(0, 0, 0);
    trans = 0;
    prev_st = int'(state);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 1'($urandom));
      if (int'(state) != prev_st) trans++;
      prev_st = int'(state);
    end
    check("held_btn_transitions", trans, 1);
    check("held_btn_state", int'(state), 1);

    // Press while the counter is 4
    roll(4);
    check("roll4_num", int'(num), 4);
    check("roll4_state", int'(state), 2);

    // Reset in CHOOSE coinciding with a take press
    cyc(0, 0, 1);
    cyc(1, 1, 1);
    check("rst_choose_state", int'(state), 0);
    check("rst_choose_num", int'(num), 0);
    check("rst_choose_scores", int'(scores), 0);
    check("rst_choose_turns", int'(turns), 0);

    // P0 takes 6, P1 passes, P0 takes 4 -> exact win
    start();
    take(6);
    pass(3);
    take(4);
    check("win_scores", int'(scores), 'h0A);
    check("win_won", int'(won), 1);
    check("win_winner", int'(winner), 0);
    check("win_state", int'(state), 3);
    check("win_turns", int'(turns), 3);

    // Press in DONE clears everything
    choose(1);
    check("clear_state", int'(state), 0);
    check("clear_scores", int'(scores), 0);
    check("clear_won", int'(won), 0);

    // P0 reaches 8 then overshoots with 5 -> bust
    start();
    take(4);
    pass(2);
    take(4);
    pass(2);
    take(5);
    check("bust_pulse", int'(bust), 1);
    check("bust_scores", int'(scores), 'h08);
    check("bust_player", int'(player), 1);
    check("bust_turns", int'(turns), 5);
    check("bust_state", int'(state), 1);
    cyc(0, 0, 0);
    check("bust_one_cycle", int'(bust), 0);
    // P1 takes 3 on the last turn -> draw
    take(3);
    check("draw_state", int'(state), 3);
    check("draw_won", int'(won), 0);
    check("draw_turns", int'(turns), 6);
    check("draw_scores", int'(scores), 'h38);
    choose(0);
    check("clear2_state", int'(state), 0);
    check("clear2_turns", int'(turns), 0);

    // Everyone passes until MAX_TURNS
    start();
    for (int i = 0; i < MAX_TURNS; i++) pass(1 + (i % FACES));
    check("allpass_state", int'(state), 3);
    check("allpass_won", int'(won), 0);
    check("allpass_turns", int'(turns), MAX_TURNS);
    choose(1);
    check("allpass_clear", int'(state), 0);

    // Win on the final permitted turn takes priority over the draw
    start();
    pass(2);
    take(6);
    pass(5);
    pass(1);
    pass(3);
    take(4);
    check("lastturn_won", int'(won), 1);
    check("lastturn_winner", int'(winner), 1);
    check("lastturn_state", int'(state), 3);
    check("lastturn_turns", int'(turns), MAX_TURNS);
    check("lastturn_scores", int'(scores), 'hA0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dice_game_mp.md
DICE_GAME_MP -- requirements
Module: dice_game_mp

Interface
REQ-001 Parameter PLAYERS, default 2: number of players, legal range 1..4.
REQ-002 Parameter FACES, default 6: die faces, legal range 2..7; rolls take values 1..FACES.
REQ-003 Parameter TARGET, default 15: exact score a player must reach to win.
REQ-004 Parameter MAX_TURNS, default 12: total completed turns, across all players, before the game ends in a draw.
REQ-005 Parameter SCORE_W, default 4: per-player score width; TARGET SHALL fit in SCORE_W bits.
REQ-006 Parameter TURN_W, default 4: turn counter width; MAX_TURNS SHALL fit in TURN_W bits.
REQ-007 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1: synchronous, active-high reset.
REQ-009 Port btn, input, 1: active-high button level; only its rising edge acts.
REQ-010 Port choice, input, 1: in CHOOSE, 1 = take the roll, 0 = pass.
REQ-011 Port state, output, 2: game state, encoded IDLE=0, ROLL=1, CHOOSE=2, DONE=3.
REQ-012 Port num, output, 3: last latched roll.
REQ-013 Port player, output, 2: index of the current player.
REQ-014 Port score, output, SCORE_W: current player's score.
REQ-015 Port scores, output, PLAYERS*SCORE_W: all scores, with player i at bits [i*SCORE_W +: SCORE_W].
REQ-016 Port turns, output, TURN_W: completed turn count.
REQ-017 Port won, output, 1: high in DONE when a player won.
REQ-018 Port winner, output, 2: index of the winning player; valid only when won=1.
REQ-019 Port bust, output, 1: one-cycle pulse marking a rejected take.

Function
REQ-020 The block SHALL register btn into btn_q every cycle; press = btn & ~btn_q; holding btn high SHALL produce exactly one press.
REQ-021 All outputs SHALL be registered; a press sampled at edge N SHALL be reflected in the outputs after edge N.
REQ-022 IDLE: on press, the block SHALL go to ROLL; otherwise it SHALL hold.
REQ-023 ROLL: an internal counter SHALL step 1,2,..,FACES,1 each cycle; on press, num SHALL take the counter value sampled at that edge and state SHALL go to CHOOSE.
REQ-024 The roll counter SHALL reload to 1 on entry to ROLL.
REQ-025 CHOOSE, on press with choice=1: sum = score[player] + num, computed in SCORE_W+1 bits.
REQ-026 If sum == TARGET, score[player] SHALL take sum, won=1, winner=player, and state SHALL go to DONE; turns SHALL increment.
REQ-027 If sum > TARGET, the score SHALL be unchanged and bust SHALL pulse high for exactly one cycle.
REQ-028 If sum < TARGET, score[player] SHALL take sum.
REQ-029 choice=0 SHALL leave the score unchanged, with no bust pulse.
REQ-030 On every non-winning confirm, turns SHALL increment, player SHALL advance (PLAYERS-1 wraps to 0), and state SHALL return to ROLL.
REQ-031 If the incremented turns equals MAX_TURNS and there is no win, state SHALL go to DONE with won=0; a win on that same confirm takes priority (won=1).
REQ-032 DONE: on press, the block SHALL clear scores, turns, player, won, winner and num, and go to IDLE.
REQ-033 In IDLE and DONE the choice input SHALL be ignored; in ROLL it SHALL also be ignored.
REQ-034 With PLAYERS=1, player SHALL remain 0.

Reset
REQ-035 When rst=1 at a clock edge, the block SHALL set state=IDLE, num=0, player=0, all scores=0, turns=0, won=0, winner=0, bust=0, btn_q=1, and roll counter=1.
REQ-036 rst SHALL dominate a simultaneous press in any state, including mid-CHOOSE.
REQ-037 Resetting btn_q to 1 SHALL ensure a button held through reset gives no press.

Verification
REQ-038 Reset, then btn held high for 10 cycles -> state goes 0->1 exactly once, with no further transition.
REQ-039 FACES=6, press while the counter equals 4 -> num=4 and state=2 on the next cycle.
REQ-040 PLAYERS=2, TARGET=10: P0 takes 6, P1 passes, P0 takes 4 -> scores={0,10}, won=1, winner=0, state=3, turns=3.
REQ-041 P0 score=8, TARGET=10, P0 takes a roll of 5 -> bust high for 1 cycle, score stays 8, player=1, turns incremented.
REQ-042 MAX_TURNS=3 with every player passing -> after the third confirm, state=3, won=0, turns=3; the next press -> state=0 and all cleared.
REQ-043 rst=1 in CHOOSE in the same cycle as a press -> all outputs at their reset values on the next cycle, with no score update.
